piso_tx: RTL and testbench

- Parallel-in, serial-out transmitter. It loads a WIDTH-bit word and shifts it out MSB-first, one bit per rising Clk edge.
- It is the sending end of the storage path: it launches the bit stream that the team's latch and flip-flop cells capture downstream.
- Q/nQ form a complementary serial output pair. It is built from edge-triggered storage, not transparent latches.

---
 rtl/piso_tx_pkg.sv | 9 +
 rtl/piso_tx_dff_ar.sv | 20 ++
 rtl/piso_tx.sv | 59 +++++
 tb/tb_piso_tx.sv | 96 +++++++++
 4 files changed

// File: rtl/piso_tx_pkg.sv
// piso_tx_pkg: state encoding and default word width shared by the piso_tx slice.
package piso_tx_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;
  localparam int WIDTH_DEF = 4;
endpackage

// File: rtl/piso_tx_dff_ar.sv
// dff_ar: rising-edge master-slave D flip-flop with async active-high reset and Q/nQ outputs.
module dff_ar (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic qn
);
  logic m_q;
  // Master is transparent while clk is low; slave takes its value on the rising edge.
  always_latch begin
    if (rst) m_q <= 1'b0;
    else if (!clk) m_q <= d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else q <= m_q;
  end
  assign qn = ~q;
endmodule

// File: rtl/piso_tx.sv
// piso_tx: loads a WIDTH-bit word and shifts it out MSB-first on Q/nQ with Busy/Done status.
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW    = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Load,
  input  logic [WIDTH-1:0] Din,
  output logic             Q,
  output logic             nQ,
  output logic             Busy,
  output logic             Done
);
  logic [1:0]       st_q, st_n, st_d;
  logic             q_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             idle, accept;
  // Status decodes use both rails so the unreachable code 2'b11 reads as neither busy nor done.
  assign idle   = st_n[1] & st_n[0];
  assign Busy   = st_n[1] & st_q[0];
  assign Done   = st_q[1] & st_n[0];
  assign accept = (idle | Done) & Load;
  always_comb begin
    st_d    = IDLE;
    q_d     = 1'b0;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (accept) begin
      st_d    = SHIFT;
      q_d     = Din[WIDTH-1];
      shreg_d = Din;
      cnt_d   = CW'(WIDTH - 1);
    end else if (Busy && cnt_q != '0) begin
      st_d    = SHIFT;
      q_d     = shreg_q[WIDTH-2];
      shreg_d = shreg_q << 1;
      cnt_d   = cnt_q - CW'(1);
    end else if (Busy) begin
      st_d = DONE;
    end
  end
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end
  for (genvar i = 0; i < 2; i++) begin : g_st
    dff_ar u_st (.clk(Clk), .rst(Rst), .d(st_d[i]), .q(st_q[i]), .qn(st_n[i]));
  end
  dff_ar u_q (.clk(Clk), .rst(Rst), .d(q_d), .q(Q), .qn(nQ));
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed-vector bench for piso_tx with hand-computed serial streams.
module tb_piso_tx;
  logic       Clk, Rst, Load;
  logic [3:0] Din;
  logic       Q, nQ, Busy, Done;
  int checks = 0;
  int failures = 0;
  piso_tx #(.WIDTH(4), .CW(4)) dut (
    .Clk(Clk), .Rst(Rst), .Load(Load), .Din(Din),
    .Q(Q), .nQ(nQ), .Busy(Busy), .Done(Done)
  );
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic outs(input string tag, input logic eq, input logic eb, input logic ed);
    chk({tag, "_q"}, {7'd0, Q}, {7'd0, eq});
    chk({tag, "_nq"}, {7'd0, nQ}, {7'd0, ~eq});
    chk({tag, "_busy"}, {7'd0, Busy}, {7'd0, eb});
    chk({tag, "_done"}, {7'd0, Done}, {7'd0, ed});
  endtask
  task automatic cyc(input string tag, input logic ld, input logic [3:0] din,
                     input logic eq, input logic eb, input logic ed);
    Load = ld;
    Din  = din;
    @(posedge Clk);
    #1;
    outs(tag, eq, eb, ed);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    Rst = 1'b1; Load = 1'b0; Din = 4'h0;
    #1;
    outs("rst0", 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc("rst_rand", 1'($urandom), 4'($urandom), 0, 0, 0);
    Rst = 1'b0;
    cyc("rel0", 0, 4'h0, 0, 0, 0);
    cyc("rel1", 0, 4'hf, 0, 0, 0);
    // single word 1011
    cyc("s0", 1, 4'b1011, 1, 1, 0);
    cyc("s1", 0, 4'h0, 0, 1, 0);
    cyc("s2", 0, 4'h0, 1, 1, 0);
    cyc("s3", 0, 4'h0, 1, 1, 0);
    cyc("s4", 0, 4'h0, 0, 0, 1);
    cyc("s5", 0, 4'h0, 0, 0, 0);
    // load during shift is ignored
    cyc("ld0", 1, 4'b1011, 1, 1, 0);
    cyc("ld1", 0, 4'h0, 0, 1, 0);
    cyc("ld2", 1, 4'b0100, 1, 1, 0);
    cyc("ld3", 1, 4'b0100, 1, 1, 0);
    cyc("ld4", 0, 4'h0, 0, 0, 1);
    cyc("ld5", 0, 4'h0, 0, 0, 0);
    cyc("ld6", 0, 4'h0, 0, 0, 0);
    // back-to-back: 1100 then 0011 accepted in the DONE cycle
    cyc("bb0", 1, 4'b1100, 1, 1, 0);
    cyc("bb1", 0, 4'h0, 1, 1, 0);
    cyc("bb2", 0, 4'h0, 0, 1, 0);
    cyc("bb3", 0, 4'h0, 0, 1, 0);
    cyc("bb4", 1, 4'b0011, 0, 0, 1);
    cyc("bb5", 1, 4'b0011, 0, 1, 0);
    cyc("bb6", 0, 4'h0, 0, 1, 0);
    cyc("bb7", 0, 4'h0, 1, 1, 0);
    cyc("bb8", 0, 4'h0, 1, 1, 0);
    cyc("bb9", 0, 4'h0, 0, 0, 1);
    cyc("bb10", 0, 4'h0, 0, 0, 0);
    // mid-word reset aborts without a Done pulse
    cyc("mr0", 1, 4'b1111, 1, 1, 0);
    cyc("mr1", 0, 4'h0, 1, 1, 0);
    #2;
    Rst = 1'b1;
    #1;
    outs("mr_async", 0, 0, 0);
    cyc("mr_hold0", 1, 4'hf, 0, 0, 0);
    cyc("mr_hold1", 0, 4'h0, 0, 0, 0);
    Rst = 1'b0;
    cyc("mr_idle0", 0, 4'h0, 0, 0, 0);
    cyc("mr_idle1", 0, 4'h0, 0, 0, 0);
    cyc("nw0", 1, 4'b1001, 1, 1, 0);
    cyc("nw1", 0, 4'h0, 0, 1, 0);
    cyc("nw2", 0, 4'h0, 0, 1, 0);
    cyc("nw3", 0, 4'h0, 1, 1, 0);
    cyc("nw4", 0, 4'h0, 0, 0, 1);
    cyc("nw5", 0, 4'h0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
